// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ser_state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - b_in, with borrow out. Purely combinational.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first; result valid WIDTH cycles after accept and held until out_ready.
// Optional signed-overflow flag on port ovf when SIGNED_OVF_EN is defined.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bor_q, bor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_d, cell_bout;
  logic             last_bit;

`ifdef SIGNED_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .b_in (bor_q),
    .d    (cell_d),
    .b_out(cell_bout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
`ifdef SIGNED_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SIGNED_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        bor_d  = cell_bout;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
`ifdef SIGNED_OVF_EN
          // The cell output on the final edge is the result MSB.
          ovf_d = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef SIGNED_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
`ifdef SIGNED_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = res_q;
  assign borrow_out = bor_q;
`ifdef SIGNED_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;
`ifdef SIGNED_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out),
    .busy      (busy)
`ifdef SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; hold = cycles to stall out_ready in DONE, noisy = junk inputs during RUN.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int hold, input bit noisy);
    int          lat;
    int          ea, eb;
    logic [W-1:0] exp_diff;
    logic         exp_bor;
    logic [W-1:0] d0;
    logic         b0;
    bit           stable;
    ea       = int'(av);
    eb       = int'(bv);
    exp_diff = W'((ea - eb + (1 << W)) % (1 << W));
    exp_bor  = (ea < eb);
    check("in_ready_idle", in_ready, 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    lat = 0;
    while (!out_valid && lat < W + 4) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = W'($urandom);
        b        = W'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, W);
    if (hold > 0) begin
      d0     = diff;
      b0     = borrow_out;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (diff !== d0 || borrow_out !== b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
          stable = 1'b0;
      end
      check("hold_stable", stable, 1);
      out_ready = 1'b1;
    end
    check("diff", diff, exp_diff);
    check("borrow_out", borrow_out, exp_bor);
`ifdef SIGNED_OVF_EN
    begin
      int sd;
      sd = int'($signed(av)) - int'($signed(bv));
      check("ovf", ovf, (sd < -(1 << (W - 1)) || sd > (1 << (W - 1)) - 1));
    end
`endif
    tick();
    check("out_valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef SIGNED_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    tick();

    do_op(8'd100, 8'd37, 0, 1'b0);
    do_op(8'd5, 8'd9, 0, 1'b0);
    do_op(8'd0, 8'd255, 0, 1'b0);
    do_op(8'h80, 8'h01, 0, 1'b0);
    do_op(8'h05, 8'h03, 0, 1'b0);
    do_op(8'd77, 8'd77, 0, 1'b0);
    do_op(8'h7F, 8'h80, 0, 1'b0);
    do_op(8'd200, 8'd13, 20, 1'b0);
    do_op(8'd18, 8'd250, 0, 1'b1);

    // Reset three edges into RUN discards the operation.
    in_valid = 1'b1;
    a        = 8'd200;
    b        = 8'd1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_busy", busy, 0);
    check("midrun_out_valid", out_valid, 0);
    check("midrun_in_ready", in_ready, 1);
    begin
      bit pulse;
      pulse = 1'b0;
      for (int i = 0; i < W + 3; i++) begin
        tick();
        if (out_valid) pulse = 1'b1;
      end
      check("midrun_no_pulse", pulse, 0);
    end
    do_op(8'd42, 8'd42, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      do_op(W'($urandom), W'($urandom), ((n % 5) == 0) ? int'($urandom_range(1, 6)) : 0,
            1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
